dice_roll_engine: RTL

Parametrised successor to the single-die post-processor. It consumes random words from the SIPO shift register and removes modulo bias by rejection sampling. It rolls 1..MAX_DICE dice of one selected type per request and reports each die plus the running sum. It sits between the SIPO and the UART/display path, and drives the SIPO's start control through o_stop.

---
 rtl/dice_roll_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dice_roll_engine.sv
// Bias-free dice roller: rejection-samples SIPO words into 1..N values and
// accumulates up to MAX_DICE dice per request, throttling the SIPO via o_stop.
module dice_roll_engine #(
  parameter int RAND_W     = 7,
  parameter int MAX_DICE   = 4,
  parameter int CNT_W      = 3,
  parameter int SUM_W      = 9,
  parameter int MAX_REJECT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [2:0]        i_dieSelect,
  input  logic [CNT_W-1:0]  i_numDice,
  input  logic [RAND_W-1:0] i_randomData,
  input  logic              i_valid,
  output logic              o_stop,
  output logic              o_busy,
  output logic [6:0]        o_dieRoll,
  output logic              o_dieValid,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_done,
  output logic              o_error,
  output logic [7:0]        o_rejects
);

  // state   | meaning
  // IDLE    | waiting for i_start, SIPO halted
  // COLLECT | consuming words until all dice accepted or reject limit hit
  // DONE    | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  localparam int REJ_W = $clog2(MAX_REJECT + 1);
  localparam int RANGE = 2 ** RAND_W;

  // Largest multiple of N that fits in the word range; r below it is unbiased.
  localparam logic [RAND_W:0] LIM_D4   = (RAND_W+1)'((RANGE / 4) * 4);
  localparam logic [RAND_W:0] LIM_D6   = (RAND_W+1)'((RANGE / 6) * 6);
  localparam logic [RAND_W:0] LIM_D8   = (RAND_W+1)'((RANGE / 8) * 8);
  localparam logic [RAND_W:0] LIM_D10  = (RAND_W+1)'((RANGE / 10) * 10);
  localparam logic [RAND_W:0] LIM_D12  = (RAND_W+1)'((RANGE / 12) * 12);
  localparam logic [RAND_W:0] LIM_D20  = (RAND_W+1)'((RANGE / 20) * 20);
  localparam logic [RAND_W:0] LIM_D100 = (RAND_W+1)'((RANGE / 100) * 100);

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REJ_W-1:0]   run_q, run_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic [6:0]         roll_q, roll_d;
  logic               die_valid_q, die_valid_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [7:0]         rejects_q, rejects_d;

  logic [RAND_W:0]    lim;
  logic [RAND_W-1:0]  mod_v;
  logic [6:0]         roll_v;
  logic               accept;
  logic [CNT_W-1:0]   num_clamped;

  // Constant-divisor mod per die type, selected by the latched die type.
  always_comb begin
    lim   = LIM_D100;
    mod_v = i_randomData % RAND_W'(100);
    case (sel_q)
      3'd0: begin lim = LIM_D4;  mod_v = i_randomData % RAND_W'(4);  end
      3'd1: begin lim = LIM_D6;  mod_v = i_randomData % RAND_W'(6);  end
      3'd2: begin lim = LIM_D8;  mod_v = i_randomData % RAND_W'(8);  end
      3'd3: begin lim = LIM_D10; mod_v = i_randomData % RAND_W'(10); end
      3'd4: begin lim = LIM_D12; mod_v = i_randomData % RAND_W'(12); end
      3'd5: begin lim = LIM_D20; mod_v = i_randomData % RAND_W'(20); end
      default: ;
    endcase
    accept = {1'b0, i_randomData} < lim;
    roll_v = 7'(mod_v) + 7'd1;
  end

  always_comb begin
    num_clamped = i_numDice;
    if (i_numDice == '0)
      num_clamped = CNT_W'(1);
    else if (i_numDice > CNT_W'(MAX_DICE))
      num_clamped = CNT_W'(MAX_DICE);
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    stop_d      = stop_q;
    busy_d      = busy_q;
    roll_d      = roll_q;
    die_valid_d = 1'b0;
    sum_d       = sum_q;
    done_d      = 1'b0;
    error_d     = error_q;
    rejects_d   = rejects_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sel_d     = i_dieSelect;
          tgt_d     = num_clamped;
          cnt_d     = '0;
          run_d     = '0;
          sum_d     = '0;
          rejects_d = '0;
          if (i_dieSelect == 3'd7) begin
            error_d = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            error_d = 1'b0;
            state_d = S_COLLECT;
            stop_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (i_valid) begin
          if (accept) begin
            roll_d      = roll_v;
            die_valid_d = 1'b1;
            sum_d       = sum_q + SUM_W'(roll_v);
            cnt_d       = cnt_q + CNT_W'(1);
            run_d       = '0;
            if (cnt_q + CNT_W'(1) == tgt_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              stop_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            if (rejects_q != 8'hFF)
              rejects_d = rejects_q + 8'd1;
            run_d = run_q + REJ_W'(1);
            if (run_q + REJ_W'(1) == REJ_W'(MAX_REJECT)) begin
              error_d = 1'b1;
              state_d = S_DONE;
              done_d  = 1'b1;
              stop_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      tgt_q       <= '0;
      cnt_q       <= '0;
      run_q       <= '0;
      stop_q      <= 1'b1;
      busy_q      <= 1'b0;
      roll_q      <= '0;
      die_valid_q <= 1'b0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rejects_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      roll_q      <= roll_d;
      die_valid_q <= die_valid_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rejects_q   <= rejects_d;
    end
  end

  assign o_stop     = stop_q;
  assign o_busy     = busy_q;
  assign o_dieRoll  = roll_q;
  assign o_dieValid = die_valid_q;
  assign o_sum      = sum_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_rejects  = rejects_q;

endmodule
